// File: rtl/merge_sort_ctrl_pkg.sv
// Shared types and default sizing for the in-place two-bank merge sorter.
package merge_sort_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_LOG_DEPTH = 5;
  localparam int unsigned DEF_DEPTH     = 1 << DEF_LOG_DEPTH;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/merge_sort_ctrl_if.sv
// Control handshake and register-file bank ports of the merge sorter.
interface merge_sort_ctrl_if
  import merge_sort_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned LOG_DEPTH = DEF_LOG_DEPTH
);
  localparam int unsigned DEPTH = 1 << LOG_DEPTH;

  logic                   start;
  logic [DEPTH*WIDTH-1:0] ReadA;
  logic [DEPTH*WIDTH-1:0] ReadB;
  logic                   WE_A;
  logic                   WE_B;
  logic [LOG_DEPTH-1:0]   WriteAddress;
  logic [WIDTH-1:0]       WriteBus;
  logic                   busy;
  logic                   done;
  logic                   result_bank;

  modport master (
    input  start, ReadA, ReadB,
    output WE_A, WE_B, WriteAddress, WriteBus, busy, done, result_bank
  );

  modport slave (
    output start, ReadA, ReadB,
    input  WE_A, WE_B, WriteAddress, WriteBus, busy, done, result_bank
  );

endinterface

// File: rtl/merge_sort_ctrl_addr_gen.sv
// Pass / run / pointer bookkeeping for bottom-up merge sort, one element per advance.
module merge_addr_gen
  import merge_sort_pkg::*;
#(
  parameter int unsigned LOG_DEPTH = DEF_LOG_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 advance_i,
  input  logic                 take_left_i,
  output logic                 src_bank_o,
  output logic [LOG_DEPTH-1:0] rd_left_o,
  output logic [LOG_DEPTH-1:0] rd_right_o,
  output logic [LOG_DEPTH-1:0] wr_addr_o,
  output logic                 left_exh_o,
  output logic                 right_exh_o,
  output logic                 last_o
);
  localparam int unsigned AW = LOG_DEPTH + 1;
  localparam int unsigned PW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

  logic [PW-1:0]        pass_q, pass_d;
  logic [AW-1:0]        lo_q, lo_d, i_q, i_d, j_q, j_d;
  logic [LOG_DEPTH-1:0] k_q, k_d;
  logic [AW-1:0]        w, left_end, right_end, i_nx, j_nx;
  logic                 pass_end, pair_end;

  always_comb begin
    w         = AW'(1) << pass_q;
    left_end  = lo_q + w;
    right_end = left_end + w;
    i_nx      = take_left_i ? i_q + AW'(1) : i_q;
    j_nx      = take_left_i ? j_q : j_q + AW'(1);
    pair_end  = (i_nx == left_end) && (j_nx == right_end);
    pass_end  = (k_q == '1);
    last_o    = pass_end && (pass_q == PW'(LOG_DEPTH - 1));

    pass_d = pass_q;
    lo_d   = lo_q;
    i_d    = i_q;
    j_d    = j_q;
    k_d    = k_q;
    // j always sits at lo + w, so a freshly started pass points it at the new width
    if (clear_i) begin
      pass_d = '0;
      lo_d   = '0;
      i_d    = '0;
      j_d    = AW'(1);
      k_d    = '0;
    end else if (advance_i) begin
      k_d = k_q + 1'b1;
      if (pass_end) begin
        pass_d = last_o ? '0 : pass_q + 1'b1;
        lo_d   = '0;
        i_d    = '0;
        j_d    = last_o ? AW'(1) : (w << 1);
      end else if (pair_end) begin
        lo_d = right_end;
        i_d  = right_end;
        j_d  = right_end + w;
      end else begin
        i_d = i_nx;
        j_d = j_nx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pass_q <= '0;
      lo_q   <= '0;
      i_q    <= '0;
      j_q    <= AW'(1);
      k_q    <= '0;
    end else begin
      pass_q <= pass_d;
      lo_q   <= lo_d;
      i_q    <= i_d;
      j_q    <= j_d;
      k_q    <= k_d;
    end
  end

  assign src_bank_o  = pass_q[0];
  assign rd_left_o   = i_q[LOG_DEPTH-1:0];
  assign rd_right_o  = j_q[LOG_DEPTH-1:0];
  assign wr_addr_o   = k_q;
  assign left_exh_o  = (i_q == left_end);
  assign right_exh_o = (j_q == right_end);

endmodule

// File: rtl/merge_sort_ctrl.sv
// Merge-sort sequencer: ping-pongs between banks A and B, one merged write per cycle.
module merge_sort_ctrl
  import merge_sort_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned LOG_DEPTH = DEF_LOG_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  merge_sort_ctrl_if.master bus
);
  localparam int unsigned DEPTH = 1 << LOG_DEPTH;

  state_e                 state_q, state_d;
  logic                   clear, advance, take_left;
  logic                   src_bank, dst_bank, left_exh, right_exh, last;
  logic [LOG_DEPTH-1:0]   rd_left, rd_right, wr_addr;
  logic [DEPTH*WIDTH-1:0] src_bus;
  logic [WIDTH-1:0]       left_val, right_val, sel_val;

  merge_addr_gen #(
    .LOG_DEPTH(LOG_DEPTH)
  ) u_addr_gen (
    .clk_i       (clock),
    .rst_ni      (reset),
    .clear_i     (clear),
    .advance_i   (advance),
    .take_left_i (take_left),
    .src_bank_o  (src_bank),
    .rd_left_o   (rd_left),
    .rd_right_o  (rd_right),
    .wr_addr_o   (wr_addr),
    .left_exh_o  (left_exh),
    .right_exh_o (right_exh),
    .last_o      (last)
  );

  assign src_bus   = (src_bank == BANK_A) ? bus.ReadA : bus.ReadB;
  assign dst_bank  = (src_bank == BANK_A) ? BANK_B : BANK_A;
  assign left_val  = src_bus[rd_left*WIDTH +: WIDTH];
  assign right_val = src_bus[rd_right*WIDTH +: WIDTH];
  // Ties go left to keep the sort stable
  assign take_left = right_exh || (!left_exh && (left_val <= right_val));
  assign sel_val   = take_left ? left_val : right_val;

  assign bus.result_bank = ((LOG_DEPTH % 2) == 1) ? BANK_B : BANK_A;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    clear            = 1'b0;
    advance          = 1'b0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    bus.WE_A         = 1'b0;
    bus.WE_B         = 1'b0;
    bus.WriteAddress = '0;
    bus.WriteBus     = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clear   = 1'b1;
          state_d = MERGE;
        end
      end
      MERGE: begin
        advance          = 1'b1;
        bus.busy         = 1'b1;
        bus.WE_A         = (dst_bank == BANK_A);
        bus.WE_B         = (dst_bank == BANK_B);
        bus.WriteAddress = wr_addr;
        bus.WriteBus     = sel_val;
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_merge_sort_ctrl.sv
// Directed bench for merge_sort_ctrl with behavioural 32x8 register-file banks.
module tb_merge_sort_ctrl;
  import merge_sort_pkg::*;

  typedef logic [7:0] img_t [32];

  logic clk;
  logic rst_n;
  logic ld_en;
  img_t ld_img;
  img_t bank_a, bank_b;
  img_t exp_final;
  logic [7:0] exp_wr [160];
  logic [7:0] wr_log [160];

  int errors = 0;
  int checks = 0;
  int n_wr, n_done, done_at, busy_low_at, we_bad, addr_bad;
  logic busy_first;

  merge_sort_ctrl_if #(.WIDTH(8), .LOG_DEPTH(5)) bus ();

  merge_sort_ctrl #(.WIDTH(8), .LOG_DEPTH(5)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.ReadA = '0;
    bus.ReadB = '0;
    for (int n = 0; n < 32; n++) begin
      bus.ReadA[n*8 +: 8] = bank_a[n];
      bus.ReadB[n*8 +: 8] = bank_b[n];
    end
  end

  always @(posedge clk) begin
    if (ld_en) begin
      bank_a <= ld_img;
      for (int n = 0; n < 32; n++) bank_b[n] <= 8'hEE;
    end else begin
      if (bus.WE_A) bank_a[bus.WriteAddress] <= bus.WriteBus;
      if (bus.WE_B) bank_b[bus.WriteAddress] <= bus.WriteBus;
    end
  end

  task automatic load(input img_t img);
    ld_img = img;
    @(negedge clk);
    ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Reference bottom-up stable merge: expected write stream and final contents
  task automatic build_model(input img_t img);
    img_t src, dst;
    int n;
    src = img;
    dst = img;
    n = 0;
    for (int p = 0; p < 5; p++) begin
      for (int lo = 0; lo < 32; lo += (2 << p)) begin
        int w, i, j, k;
        w = 1 << p;
        i = lo;
        j = lo + w;
        k = lo;
        while (i < lo + w || j < lo + 2*w) begin
          if (j >= lo + 2*w || (i < lo + w && src[i] <= src[j])) begin
            dst[k] = src[i];
            i++;
          end else begin
            dst[k] = src[j];
            j++;
          end
          exp_wr[n] = dst[k];
          k++;
          n++;
        end
      end
      src = dst;
    end
    exp_final = src;
  endtask

  task automatic run_sort(input int abort_at, input bit repulse);
    n_wr = 0; n_done = 0; done_at = 0; busy_low_at = 0;
    we_bad = 0; addr_bad = 0; busy_first = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 170; c++) begin
      if (c == abort_at) return;
      if (c == 1) busy_first = bus.busy;
      if (!bus.busy && busy_low_at == 0) busy_low_at = c;
      if (bus.done) begin
        n_done++;
        if (done_at == 0) done_at = c;
      end
      if (bus.busy) begin
        if ((bus.WE_A ^ bus.WE_B) !== 1'b1) we_bad++;
        if (bus.WE_B !== (((n_wr / 32) % 2) == 0)) we_bad++;
        if (bus.WriteAddress !== 5'(n_wr % 32)) addr_bad++;
      end else if (bus.WE_A || bus.WE_B) we_bad++;
      if (bus.WE_A || bus.WE_B) begin
        if (n_wr < 160) wr_log[n_wr] = bus.WriteBus;
        n_wr++;
      end
      bus.start = repulse && (c == 5 || c == 160);
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0;
    ld_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.WE_A, bus.WE_B, bus.busy, bus.done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000", {bus.WE_A, bus.WE_B, bus.busy, bus.done});
    end
    checks++;
    if ({bus.WriteAddress, bus.WriteBus} !== 13'd0) begin
      errors++;
      $display("FAIL reset_bus: addr=%0d data=%0h want 0/0", bus.WriteAddress, bus.WriteBus);
    end
    checks++;
    if (bus.result_bank !== BANK_B) begin
      errors++;
      $display("FAIL result_bank: got %b want 1", bus.result_bank);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_descending;
    img_t img;
    for (int n = 0; n < 32; n++) img[n] = 8'(31 - n);
    load(img);
    run_sort(0, 1'b0);
    checks++;
    if (busy_first !== 1'b1) begin
      errors++;
      $display("FAIL desc_busy_rise: busy=%b want 1", busy_first);
    end
    checks++;
    if (n_wr != 160) begin errors++; $display("FAIL desc_writes: got %0d want 160", n_wr); end
    checks++;
    if (done_at != 161 || n_done != 1) begin
      errors++;
      $display("FAIL desc_done: at=%0d pulses=%0d want 161/1", done_at, n_done);
    end
    checks++;
    if (busy_low_at != 161) begin
      errors++;
      $display("FAIL desc_busy_fall: at=%0d want 161", busy_low_at);
    end
    checks++;
    if (we_bad != 0 || addr_bad != 0) begin
      errors++;
      $display("FAIL desc_we_addr: we_bad=%0d addr_bad=%0d want 0/0", we_bad, addr_bad);
    end
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (bank_b[n] !== 8'(n)) begin
        errors++;
        $display("FAIL desc_bank_b[%0d]: got %0d want %0d", n, bank_b[n], n);
      end
    end
  endtask

  task automatic test_sorted;
    img_t img;
    int bad;
    for (int n = 0; n < 32; n++) img[n] = 8'(n);
    load(img);
    run_sort(0, 1'b0);
    bad = 0;
    for (int n = 0; n < 32; n++) if (wr_log[n] !== 8'(n)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sorted_pass0_order: bad=%0d want 0", bad); end
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (bank_b[n] !== 8'(n)) begin
        errors++;
        $display("FAIL sorted_bank_b[%0d]: got %0d want %0d", n, bank_b[n], n);
      end
    end
  endtask

  task automatic test_ties;
    img_t img;
    int bad;
    logic [7:0] want;
    for (int n = 0; n < 32; n++) img[n] = 8'h5A;
    img[7] = 8'h00;
    img[3] = 8'hFF;
    load(img);
    build_model(img);
    run_sort(0, 1'b0);
    bad = 0;
    for (int n = 0; n < 160; n++) if (wr_log[n] !== exp_wr[n]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ties_stream: bad=%0d want 0", bad); end
    for (int n = 0; n < 32; n++) begin
      want = (n == 0) ? 8'h00 : (n == 31) ? 8'hFF : 8'h5A;
      checks++;
      if (bank_b[n] !== want) begin
        errors++;
        $display("FAIL ties_bank_b[%0d]: got %0h want %0h", n, bank_b[n], want);
      end
    end
  endtask

  task automatic test_random;
    img_t img;
    int bad;
    for (int s = 1; s <= 20; s++) begin
      void'($urandom(s));
      for (int n = 0; n < 32; n++) img[n] = 8'($urandom_range(0, 9) * 23);
      load(img);
      build_model(img);
      run_sort(0, 1'b0);
      bad = 0;
      for (int n = 0; n < 160; n++) if (wr_log[n] !== exp_wr[n]) bad++;
      checks++;
      if (bad != 0 || n_wr != 160 || we_bad != 0 || addr_bad != 0 || done_at != 161) begin
        errors++;
        $display("FAIL rand_seq seed %0d: data_bad=%0d writes=%0d we_bad=%0d addr_bad=%0d done_at=%0d want 0/160/0/0/161",
                 s, bad, n_wr, we_bad, addr_bad, done_at);
      end
      for (int n = 0; n < 32; n++) begin
        checks++;
        if (bank_b[n] !== exp_final[n]) begin
          errors++;
          $display("FAIL rand_bank_b[%0d] seed %0d: got %0d want %0d", n, s, bank_b[n], exp_final[n]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    img_t img;
    for (int n = 0; n < 32; n++) img[n] = 8'((n * 11 + 3) % 32);
    load(img);
    run_sort(0, 1'b1);
    checks++;
    if (n_wr != 160 || n_done != 1 || done_at != 161) begin
      errors++;
      $display("FAIL restart_ignored: writes=%0d pulses=%0d done_at=%0d want 160/1/161", n_wr, n_done, done_at);
    end
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (bank_b[n] !== 8'(n)) begin
        errors++;
        $display("FAIL restart_bank_b[%0d]: got %0d want %0d", n, bank_b[n], n);
      end
    end
  endtask

  task automatic test_reset_abort;
    img_t img;
    for (int n = 0; n < 32; n++) img[n] = 8'((n * 13 + 5) % 64);
    load(img);
    run_sort(50, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.WE_A, bus.WE_B, bus.busy, bus.done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_outputs: got %b want 0000", {bus.WE_A, bus.WE_B, bus.busy, bus.done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 32; n++) img[n] = 8'(200 - n * 3);
    load(img);
    build_model(img);
    run_sort(0, 1'b0);
    checks++;
    if (n_wr != 160 || done_at != 161) begin
      errors++;
      $display("FAIL abort_rerun: writes=%0d done_at=%0d want 160/161", n_wr, done_at);
    end
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (bank_b[n] !== exp_final[n]) begin
        errors++;
        $display("FAIL abort_bank_b[%0d]: got %0d want %0d", n, bank_b[n], exp_final[n]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_descending;
    test_sorted;
    test_ties;
    test_random;
    test_back_to_back;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/merge_sort_ctrl.md
# merge_sort_ctrl

Sequencer that sorts the contents of a two-bank register-file pair in place using bottom-up merge sort. It reads every entry of the current source bank through that bank's parallel read buses and writes one merged element per cycle into the other bank, ping-ponging between banks once per pass. It sits between the top-level start/done control and two 32×8 RegFile instances, bank A and bank B, and is the only writer of both banks while busy.

## Interface
- WIDTH, 8, element width in bits; comparison is unsigned
- LOG_DEPTH, 5, log2 of entries per bank; DEPTH = 2^LOG_DEPTH = 32; number of passes = LOG_DEPTH
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- start  in  1  single-cycle request to begin a sort; ignored unless IDLE
- ReadA  in  DEPTH*WIDTH  bank A read buses, entry n at bits [n*WIDTH +: WIDTH]
- ReadB  in  DEPTH*WIDTH  bank B read buses, same packing
- WE_A  out  1  write enable, bank A
- WE_B  out  1  write enable, bank B
- WriteAddress  out  LOG_DEPTH  shared write address
- WriteBus  out  WIDTH  shared write data
- busy  out  1  high during MERGE
- done  out  1  one-cycle pulse after the final write
- result_bank  out  1  bank holding the sorted result: 0 = A, 1 = B; equals LOG_DEPTH[0], so 1 for the default

## Operation
- States: IDLE, MERGE, DONE.
- IDLE: if start is high, clear pass, run-base lo, left pointer i, right pointer j and output index k; go to MERGE.
- Pass p, for p = 0..LOG_DEPTH-1, uses run width w = 2^p. The source bank is A when p is even and B when p is odd; the destination is the other bank.
- Each pair of runs occupies [lo, lo+w) (left) and [lo+w, lo+2w) (right).
- MERGE issues exactly one write each cycle:
  - Assert the destination WE.
  - WriteAddress = k.
  - WriteBus = selected element.
  - Select the left element (src[i]) if the right run is exhausted, or if the left run is not exhausted and src[i] <= src[j]. Otherwise select the right element (src[j]).
  - Ties take the left element, so the sort is stable.
  - Increment the consumed pointer and k.
- When both runs of a pair are exhausted, set lo += 2w, i = lo, j = lo + w.
- When k wraps from DEPTH-1 to 0, the pass ends: increment pass and reset lo/i/j. If the final pass has ended, go to DONE.
- DONE: done = 1 for one cycle, busy = 0, then go to IDLE.
- Pointers are LOG_DEPTH+1 bits wide so the exhausted state (pointer = run end) is representable. Address arithmetic never reads outside [0, DEPTH-1].
- Exactly one WE is asserted during MERGE, and none in IDLE or DONE.
- start while in MERGE or DONE is ignored. It is not queued.
- reset low at any point: return to IDLE and deassert all outputs at once. Bank contents are left as written. A later start re-sorts whatever bank A holds.

## Timing
- Reset values: WE_A = 0, WE_B = 0, WriteAddress = 0, WriteBus = 0, busy = 0, done = 0. result_bank is constant.
- WE_*, WriteAddress and WriteBus are combinational from registered state and the read buses. Write data is taken from the read buses in the same cycle.
- start is sampled high at edge N. busy is high after edge N.
- Writes commit at edges N+1 through N+DEPTH*LOG_DEPTH, i.e. N+1 through N+160.
- done is high between edges N+160 and N+161. busy falls at edge N+160.
- There is no gap between passes. The first read of pass p+1 happens the cycle after the last write of pass p. RegFile read buses must reflect a write by the following cycle.
- Total latency from start to done = DEPTH*LOG_DEPTH + 1 cycles. A new start is accepted from edge N+162 onward.

## Structure
- Shared package merge_sort_pkg holds:
  - the state enum (IDLE, MERGE, DONE)
  - default WIDTH and LOG_DEPTH
  - derived DEPTH
  - the bank select constants BANK_A = 0 and BANK_B = 1
- One natural sub-module, merge_addr_gen, holds the pass, lo, i, j and k counters and the run-end/exhausted flags. It takes an advance strobe and a take_left select.
- merge_sort_ctrl itself holds the FSM, source-bank mux, comparator and write-port drive.

## Test plan
- Bank A = 31..0 (descending); start pulse → 160 writes, then done one cycle later. Bank B reads 0..31 and result_bank = 1.
- Bank A already sorted 0..31 → bank B = 0..31. Writes in pass 0 alternate between left and right elements with no swaps.
- Bank A all 0x5A plus 0x00/0xFF at addresses 7/3 → bank B = 0x00, 30×0x5A, 0xFF. Stability is checked with a tagged model: on equal values the left element is taken.
- Random bank A with duplicates, 20 seeds → bank B matches a reference stable sort. Exactly one WE per busy cycle, and WriteAddress follows 0..31 in every pass.
- start re-pulsed at cycles N+5 and N+160 → ignored. Still exactly 160 writes and a single done pulse.
- reset driven low at N+50 → WE_A, WE_B, busy and done drop to 0 immediately. After release, load a fresh bank A and pulse start: the sort completes correctly with done at +161.
